uart_encoder: RTL
=================

UART_ENCODER -- requirements
Module: uart_encoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (434 x 10 ns = 4340 ns at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits per frame; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  system clock; all state rises on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_i  input  8  byte to transmit.
REQ-006 SHALL have port valid_i  input  1  data_i is valid.
REQ-007 SHALL have port ready_o  output  1  encoder can accept a byte.
REQ-008 SHALL have port uart_tx  output  1  serial line driven towards the DUT receive pad; idles high.
REQ-009 SHALL have port busy_o  output  1  a frame is in progress.

Function
REQ-010 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-011 SHALL accept a byte on the posedge where valid_i && ready_o, latch data_i, and go IDLE->START; later changes to data_i SHALL be ignored.
REQ-012 SHALL assert ready_o only in IDLE; busy_o SHALL be the inverse of ready_o.
REQ-013 SHALL drive uart_tx low for the start bit from the first cycle after acceptance (latency 1 cycle).
REQ-014 SHALL hold each bit for exactly CLKS_PER_BIT cycles, with the bit timer counting 0..CLKS_PER_BIT-1 and wrapping to 0 on every bit boundary.
REQ-015 SHALL send the DATA bits LSB first, with a 3-bit index counting 0..7; START->DATA after 1 bit time, DATA->PARITY or STOP after bit 7.
REQ-016 SHALL drive uart_tx high for STOP_BITS x CLKS_PER_BIT cycles in STOP, then enter IDLE.
REQ-017 SHALL keep uart_tx high in IDLE.
REQ-018 SHALL give back-to-back frames a period of exactly (10 + P + STOP_BITS - 1) x CLKS_PER_BIT + 1 cycles when valid_i is held high, where P = 1 with parity and 0 without; the single extra cycle is the IDLE acceptance cycle.
REQ-019 SHALL size the bit-timer width as $clog2(CLKS_PER_BIT) so that it never overflows.

Reset
REQ-020 SHALL, while rst is asserted, force state=IDLE, uart_tx=1, ready_o=1, busy_o=0, and clear the timer and index to 0, asynchronously.
REQ-021 SHALL, on reset mid-frame, discard the partial frame and return the line high immediately, with no glitch low after release.
REQ-022 SHALL NOT accept a byte in the cycle rst deasserts unless valid_i is sampled high at that posedge with ready_o=1.

Configuration
REQ-023 SHALL, with UART_ENCODER_PARITY_EN defined, insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-024 SHALL, without UART_ENCODER_PARITY_EN, remove the PARITY state and its logic; DATA->STOP directly (8N1 / 8N2).

Structure
REQ-025 SHALL put the state enum and the FRAME_DATA_BITS=8 constant in package uart_encoder_pkg.
REQ-026 SHALL put bit timing in sub-module uart_baud_tick, which takes clk, rst and a restart input, emits a 1-cycle tick at the end of each bit period, and is parameterised by CLKS_PER_BIT.

Verification
REQ-027 SHALL check: CLKS_PER_BIT=4, 8N1, send 0x55 -> uart_tx = 0 then 1,0,1,0,1,0,1,0 then 1, each bit held 4 cycles, start bit low at acceptance+1, and ready_o high again after 40 cycles.
REQ-028 SHALL check: back-to-back 0xA5 then 0x3C with valid_i held -> second start bit falls exactly 41 cycles after the first, with the LSB-first bit patterns correct.
REQ-029 SHALL check: rst pulsed at cycle 17 of a 0xFF frame -> uart_tx goes 1 asynchronously, ready_o=1, and the next byte 0x00 is sent cleanly.
REQ-030 SHALL check: with UART_ENCODER_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 11 bit times.
REQ-031 SHALL check: STOP_BITS=2, send 0x80 -> stop high for 8 cycles at CLKS_PER_BIT=4, and the next start is no earlier than that.
REQ-032 SHALL check: loopback into uart_decoder at the default CLKS_PER_BIT=434 and 100 MHz clk, with the string "OK\n" -> the decoder prints "OK".

Source files
------------

// File: rtl/uart_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_encoder_pkg
// Purpose  : Shared types and constants for the UART encoder: FSM state
//            encoding and the number of data bits per frame.
// Config   : UART_ENCODER_PARITY_EN adds the PARITY state to the encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_encoder_pkg;

  localparam int FRAME_DATA_BITS = 8;

`ifdef UART_ENCODER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

endpackage : uart_encoder_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and emits a one-cycle
//            tick on the last cycle of each bit period. While restart is high
//            the counter is held at 0 so the first bit after it is full length.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            restart  - hold the timer at the start of a bit period
//            tick     - high on the final cycle of a bit period
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !restart && (count == LAST);

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_encoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_encoder
// Purpose  : UART transmitter, 8 data bits LSB first, 1 or 2 stop bits,
//            optional even parity. valid/ready byte handshake.
// Config   : define UART_ENCODER_PARITY_EN to insert an even-parity bit
//            between the data bits and the stop bit(s).
// Ports    : clk     - system clock
//            rst     - asynchronous active-high reset
//            data_i  - byte to transmit, latched on acceptance
//            valid_i - data_i is valid
//            ready_o - encoder is idle and can accept a byte
//            uart_tx - serial output, idles high
//            busy_o  - a frame is in progress (inverse of ready_o)
// Revision : 1.0 - initial release
// ============================================================================
module uart_encoder
  import uart_encoder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       uart_tx,
  output logic       busy_o
);

  localparam logic [2:0] LAST_DATA = 3'(FRAME_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t     state, state_next;
  logic [2:0] idx, idx_next;
  logic [7:0] shreg, shreg_next;
  logic       tx_next;
  logic       bit_tick;
  logic       restart;

  // Timer is parked at 0 while idle so the start bit gets a full period.
  assign restart = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      shreg   <= shreg_next;
      uart_tx <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    shreg_next = shreg;
    case (state)
      IDLE: begin
        if (valid_i) begin
          shreg_next = data_i;
          idx_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_tick) begin
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx == LAST_DATA) begin
            idx_next   = '0;
`ifdef UART_ENCODER_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
`ifdef UART_ENCODER_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          idx_next   = '0;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        // idx counts stop bits here so 8N2 reuses the same counter.
        if (bit_tick) begin
          if (idx == LAST_STOP) begin
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      default: begin
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Line level is registered from the next state so uart_tx is glitch-free
  // and the start bit appears in the first cycle after acceptance.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[idx_next];
`ifdef UART_ENCODER_PARITY_EN
      PARITY:  tx_next = ^shreg_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign ready_o = (state == IDLE);
  assign busy_o  = !ready_o;

endmodule : uart_encoder
`default_nettype wire
